// File: rtl/divider32by16_seq.sv
// Sequential restoring divider: 32-bit / 16-bit -> saturated 16-bit quotient and exact remainder.
// Optional macro DIV_FASTOVF_EN: skip the upper 16 iterations when the quotient fits in 16 bits.
module divider32by16_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        ovf,
  output logic        dbz
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] rem_q, rem_d;
  logic [31:0] dvd_q, dvd_d;
  logic [15:0] dsr_q, dsr_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [15:0] quo_q, quo_d;
  logic [15:0] rmd_q, rmd_d;
  logic        ovf_q, ovf_d;
  logic        dbz_q, dbz_d;

  logic        accept;
  logic        last_iter;
  logic [16:0] trial;
  logic [16:0] diff;
  logic        qbit;
  logic [15:0] rem_next;
  logic [31:0] q_full;
  logic        q_ovf;

  assign accept    = (state_q == StIdle) && in_valid;
  assign last_iter = (cnt_q == 6'd1);

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign trial    = {rem_q, dvd_q[31]};
  assign diff     = trial - {1'b0, dsr_q};
  assign qbit     = (trial >= {1'b0, dsr_q});
  assign rem_next = qbit ? diff[15:0] : trial[15:0];
  assign q_full   = {dvd_q[30:0], qbit};
  assign q_ovf    = |q_full[31:16];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = (divisor == 16'd0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (last_iter) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    quotient  = quo_q;
    remainder = rmd_q;
    ovf       = ovf_q;
    dbz       = dbz_q;
  end

  always_comb begin
    rem_d = rem_q;
    dvd_d = dvd_q;
    dsr_d = dsr_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rmd_d = rmd_q;
    ovf_d = ovf_q;
    dbz_d = dbz_q;
    if (accept) begin
      dsr_d = divisor;
      if (divisor == 16'd0) begin
        quo_d = 16'hFFFF;
        rmd_d = dividend[15:0];
        ovf_d = 1'b0;
        dbz_d = 1'b1;
      end else begin
`ifdef DIV_FASTOVF_EN
        if (dividend[31:16] >= divisor) begin
          rem_d = 16'd0;
          dvd_d = dividend;
          cnt_d = 6'd32;
        end else begin
          // Upper half already below the divisor: it is the partial remainder after 16 steps.
          rem_d = dividend[31:16];
          dvd_d = {dividend[15:0], 16'h0000};
          cnt_d = 6'd16;
        end
`else
        rem_d = 16'd0;
        dvd_d = dividend;
        cnt_d = 6'd32;
`endif
      end
    end else if (state_q == StRun) begin
      rem_d = rem_next;
      dvd_d = q_full;
      cnt_d = cnt_q - 6'd1;
      if (last_iter) begin
        quo_d = q_ovf ? 16'hFFFF : q_full[15:0];
        rmd_d = rem_next;
        ovf_d = q_ovf;
        dbz_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= 16'd0;
      dvd_q <= 32'd0;
      dsr_q <= 16'd0;
      cnt_q <= 6'd0;
      quo_q <= 16'd0;
      rmd_q <= 16'd0;
      ovf_q <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      dvd_q <= dvd_d;
      dsr_q <= dsr_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rmd_q <= rmd_d;
      ovf_q <= ovf_d;
      dbz_q <= dbz_d;
    end
  end

endmodule
